// File: rtl/spi_master_param_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_master_param_if
// Brief    : Word handshake and SPI pin bundle; MISO pins exist with SPI_MISO_EN.
// Revision : 1.0
// ============================================================================
interface spi_master_param_if #(
   parameter int WIDTH = 16
) ();
   logic [WIDTH-1:0] tx_data;
   logic             tx_last;
   logic             tx_valid;
   logic             tx_ready;
   logic             busy;
   logic             done;
   logic             sck;
   logic             mosi;
   logic             cs_n;
`ifdef SPI_MISO_EN
   logic             miso;
   logic [WIDTH-1:0] rx_data;
   logic             rx_valid;

   modport master (
      input  tx_data, tx_last, tx_valid, miso,
      output tx_ready, busy, done, sck, mosi, cs_n, rx_data, rx_valid
   );
   modport slave (
      output tx_data, tx_last, tx_valid, miso,
      input  tx_ready, busy, done, sck, mosi, cs_n, rx_data, rx_valid
   );
`else
   modport master (
      input  tx_data, tx_last, tx_valid,
      output tx_ready, busy, done, sck, mosi, cs_n
   );
   modport slave (
      output tx_data, tx_last, tx_valid,
      input  tx_ready, busy, done, sck, mosi, cs_n
   );
`endif
endinterface
`default_nettype wire

// File: rtl/spi_master_param.sv
`default_nettype none
// ============================================================================
// Module   : spi_master_param
// Brief    : Parametrised SPI master with CS-held bursts; SPI_MISO_EN adds capture.
// Revision : 1.0
// ============================================================================
module spi_master_param #(
   parameter int WIDTH = 16,
   parameter int DIV   = 2,
   parameter bit CPOL  = 1'b0,
   parameter bit CPHA  = 1'b0,
   parameter int GAP   = 1
) (
   input  wire logic          clk,
   input  wire logic          res,
   spi_master_param_if.master bus
);
   localparam int C_CNT_MAX = (DIV > GAP) ? ((DIV > 1) ? DIV : 2) : ((GAP > 1) ? GAP : 2);
   localparam int C_CW      = $clog2(C_CNT_MAX);
   localparam int C_BW      = $clog2(WIDTH);
   localparam logic [C_CW-1:0] C_DIV_LAST = C_CW'(DIV - 1);
   localparam logic [C_CW-1:0] C_GAP_LAST = C_CW'(GAP - 1);
   localparam logic [C_BW-1:0] C_BIT_LAST = C_BW'(WIDTH - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SETUP = 3'd1,
      S_SHIFT = 3'd2,
      S_HOLD  = 3'd3,
      S_CHAIN = 3'd4,
      S_GAP   = 3'd5
   } state_t;

   state_t           r_state;
   logic [C_CW-1:0]  r_cnt;
   logic [C_BW-1:0]  r_bit;
   logic             r_lead;
   logic             r_tail;
   logic [WIDTH-1:0] r_sh;
   logic             r_last;
   logic             r_sck;
   logic             r_mosi;
   logic             r_cs_n;
   logic             r_busy;
   logic             r_done;
`ifdef SPI_MISO_EN
   logic [WIDTH-1:0] r_rx_sh;
   logic [WIDTH-1:0] r_rx_data;
   logic             r_rx_valid;
`endif

   logic w_ready;
   logic w_accept;
   logic w_tick;

   assign w_ready  = ((r_state == S_IDLE) || (r_state == S_CHAIN)) & ~res;
   assign w_accept = bus.tx_valid & w_ready;
   assign w_tick   = (r_cnt == C_DIV_LAST);

   always_ff @(posedge clk) begin
      if (res) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_bit   <= '0;
         r_lead  <= 1'b1;
         r_tail  <= 1'b0;
         r_sh    <= '0;
         r_last  <= 1'b0;
         r_sck   <= CPOL;
         r_mosi  <= 1'b0;
         r_cs_n  <= 1'b1;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
`ifdef SPI_MISO_EN
         r_rx_sh    <= '0;
         r_rx_data  <= '0;
         r_rx_valid <= 1'b0;
`endif
      end else begin
         r_done <= 1'b0;
`ifdef SPI_MISO_EN
         r_rx_valid <= 1'b0;
`endif
         case (r_state)
            S_IDLE, S_CHAIN: begin
               if (w_accept) begin
                  // CPHA=0 presents the MSB immediately, so the register holds the remaining bits
                  r_sh   <= CPHA ? bus.tx_data : {bus.tx_data[WIDTH-2:0], 1'b0};
                  if (!CPHA) r_mosi <= bus.tx_data[WIDTH-1];
                  r_last  <= bus.tx_last;
                  r_cs_n  <= 1'b0;
                  r_busy  <= 1'b1;
                  r_cnt   <= '0;
                  r_bit   <= '0;
                  r_lead  <= 1'b1;
                  r_tail  <= 1'b0;
                  r_state <= S_SETUP;
               end
            end
            S_SETUP, S_SHIFT: begin
               r_cnt <= w_tick ? '0 : r_cnt + C_CW'(1);
               if (w_tick) begin
                  if (r_tail) begin
                     r_state <= S_HOLD;
                  end else begin
                     r_state <= S_SHIFT;
                     r_sck   <= ~r_sck;
                     r_lead  <= ~r_lead;
                     if (r_lead == CPHA) begin
                        if (CPHA || (r_bit != C_BIT_LAST)) begin
                           r_mosi <= r_sh[WIDTH-1];
                           r_sh   <= {r_sh[WIDTH-2:0], 1'b0};
                        end
                     end else begin
`ifdef SPI_MISO_EN
                        r_rx_sh <= {r_rx_sh[WIDTH-2:0], bus.miso};
`endif
                     end
                     if (!r_lead) begin
                        if (r_bit == C_BIT_LAST) r_tail <= 1'b1;
                        else                     r_bit  <= r_bit + C_BW'(1);
                     end
                  end
               end
            end
            S_HOLD: begin
               r_cnt <= w_tick ? '0 : r_cnt + C_CW'(1);
               if (w_tick) begin
                  r_done <= 1'b1;
                  r_busy <= 1'b0;
`ifdef SPI_MISO_EN
                  r_rx_data  <= r_rx_sh;
                  r_rx_valid <= 1'b1;
`endif
                  if (r_last) begin
                     r_cs_n  <= 1'b1;
                     r_state <= (GAP == 0) ? S_IDLE : S_GAP;
                  end else begin
                     r_state <= S_CHAIN;
                  end
               end
            end
            S_GAP: begin
               if (r_cnt == C_GAP_LAST) begin
                  r_cnt   <= '0;
                  r_state <= S_IDLE;
               end else begin
                  r_cnt <= r_cnt + C_CW'(1);
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.tx_ready = w_ready;
   assign bus.busy     = r_busy;
   assign bus.done     = r_done;
   assign bus.sck      = r_sck;
   assign bus.mosi     = r_mosi;
   assign bus.cs_n     = r_cs_n;
`ifdef SPI_MISO_EN
   assign bus.rx_data  = r_rx_data;
   assign bus.rx_valid = r_rx_valid;
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_master_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_master_param
// Brief    : Mode-0 and mode-3 SPI masters driven with directed and random words.
// Revision : 1.0
// ============================================================================
module tb_spi_master_param;
   logic clk = 1'b0;
   logic res_a, res_b;
   int   checks = 0;
   int   errors = 0;
   bit   sel    = 1'b0;
   bit   mon_en = 1'b0;

   always #5 clk = ~clk;

   spi_master_param_if #(.WIDTH(16)) A ();
   spi_master_param_if #(.WIDTH(8))  B ();

   spi_master_param #(.WIDTH(16), .DIV(2), .CPOL(1'b0), .CPHA(1'b0), .GAP(3))
      u_a (.clk(clk), .res(res_a), .bus(A.master));
   spi_master_param #(.WIDTH(8), .DIV(1), .CPOL(1'b1), .CPHA(1'b1), .GAP(1))
      u_b (.clk(clk), .res(res_b), .bus(B.master));

`ifdef SPI_MISO_EN
   assign A.miso = A.mosi;
   assign B.miso = B.mosi;
`endif

   // A slave samples on rising SCK in both modes; record the MOSI level just before each rise
   int          a_rises = 0, b_rises = 0, b_bad = 0;
   logic [63:0] a_cap = '0, b_cap = '0;
   logic        a_psck = 1'b0, a_pmosi = 1'b0, b_psck = 1'b1, b_pmosi = 1'b0;

   always @(negedge clk) begin
      a_psck  <= A.sck;
      a_pmosi <= A.mosi;
      if (A.sck === 1'b1 && a_psck === 1'b0) begin
         a_rises <= a_rises + 1;
         a_cap   <= {a_cap[62:0], a_pmosi};
      end
   end

   always @(negedge clk) begin
      b_psck  <= B.sck;
      b_pmosi <= B.mosi;
      if (B.sck === 1'b1 && b_psck === 1'b0) begin
         b_rises <= b_rises + 1;
         b_cap   <= {b_cap[62:0], b_pmosi};
      end
      if (mon_en && (B.mosi !== b_pmosi) && !(b_psck === 1'b1 && B.sck === 1'b0))
         b_bad <= b_bad + 1;
   end

   localparam int K_RDY = 0, K_DONE = 1, K_CS = 2, K_BUSY = 3, K_SCK = 4;
   localparam int K_MOSI = 5, K_RISES = 6, K_CAP = 7, K_RXD = 8, K_RXV = 9;

   function automatic logic [31:0] obs(input int k);
      logic [31:0] v;
      v = '0;
      case (k)
         K_RDY:   v = 32'(sel ? B.tx_ready : A.tx_ready);
         K_DONE:  v = 32'(sel ? B.done : A.done);
         K_CS:    v = 32'(sel ? B.cs_n : A.cs_n);
         K_BUSY:  v = 32'(sel ? B.busy : A.busy);
         K_SCK:   v = 32'(sel ? B.sck : A.sck);
         K_MOSI:  v = 32'(sel ? B.mosi : A.mosi);
         K_RISES: v = 32'(sel ? b_rises : a_rises);
         K_CAP:   v = sel ? {24'h0, b_cap[7:0]} : {16'h0, a_cap[15:0]};
`ifdef SPI_MISO_EN
         K_RXD:   v = sel ? {24'h0, B.rx_data} : {16'h0, A.rx_data};
         K_RXV:   v = 32'(sel ? B.rx_valid : A.rx_valid);
`endif
         default: v = '0;
      endcase
      return v;
   endfunction

   task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
      end
   endtask

   task automatic drive(input logic [15:0] d, input bit last, input bit v);
      if (sel) begin
         B.tx_data = d[7:0]; B.tx_last = last; B.tx_valid = v;
      end else begin
         A.tx_data = d;      A.tx_last = last; A.tx_valid = v;
      end
   endtask

   // Offer one word at a negedge and follow it to its done pulse; returns on the done cycle
   task automatic send(input bit s, input logic [15:0] d, input bit last, input int exp_wait);
      int t, csl, r0, w, lat;
      logic [15:0] m;
      sel = s;
      w   = s ? 8 : 16;
      lat = s ? 1 * (2 * 8 + 2) : 2 * (2 * 16 + 2);
      m   = s ? 16'h00FF : 16'hFFFF;
      drive(d, last, 1'b1);
      t = 0;
      while (obs(K_RDY) != 32'd1 && t < 50) begin @(negedge clk); t++; end
      check("accept_wait", t, exp_wait);
      r0 = int'(obs(K_RISES));
      @(negedge clk);
      drive(16'($urandom), ~last, 1'b1);
      check("cs_low_after_accept", obs(K_CS), 0);
      check("busy_after_accept", obs(K_BUSY), 1);
      check("done_low_after_accept", obs(K_DONE), 0);
`ifdef SPI_MISO_EN
      check("rx_valid_low_after_accept", obs(K_RXV), 0);
`endif
      t = 1;
      csl = 0;
      while (obs(K_DONE) != 32'd1 && t < 400) begin
         if (obs(K_CS) == 32'd0) csl++;
         @(negedge clk);
         t++;
      end
      drive(16'($urandom), 1'b0, 1'b0);
      check("done_latency", t, lat + 1);
      check("cs_low_cycles", csl, lat);
      check("cs_at_done", obs(K_CS), 32'(last));
      check("busy_at_done", obs(K_BUSY), 0);
      check("sck_idle_at_done", obs(K_SCK), 32'(s));
      check("rising_edges", obs(K_RISES) - r0, w);
      check("mosi_bits", obs(K_CAP), d & m);
`ifdef SPI_MISO_EN
      check("rx_data", obs(K_RXD), d & m);
      check("rx_valid", obs(K_RXV), 1);
`endif
   endtask

   initial begin
      int  prev_last, t, dn;
      bit  l, s;
      res_a = 1'b1; res_b = 1'b1;
      A.tx_data = '0; A.tx_last = 1'b0; A.tx_valid = 1'b0;
      B.tx_data = '0; B.tx_last = 1'b0; B.tx_valid = 1'b0;
      repeat (3) @(negedge clk);
      res_a = 1'b0; res_b = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) begin
         sel = k[0];
         check("rst_cs_n", obs(K_CS), 1);
         check("rst_sck", obs(K_SCK), 32'(k));
         check("rst_mosi", obs(K_MOSI), 0);
         check("rst_done", obs(K_DONE), 0);
         check("rst_busy", obs(K_BUSY), 0);
         check("rst_ready", obs(K_RDY), 1);
      end
      mon_en = 1'b1;
      @(negedge clk);

      send(1'b0, 16'h0C01, 1'b1, 0);
      repeat (4) @(negedge clk);
      send(1'b0, 16'h0101, 1'b0, 0);
      send(1'b0, 16'h0202, 1'b0, 0);
      send(1'b0, 16'h0303, 1'b1, 0);
      send(1'b0, 16'hA5C3, 1'b1, 3);
      @(negedge clk);
      check("done_single_cycle", obs(K_DONE), 0);
      repeat (4) @(negedge clk);
      send(1'b1, 16'h00A5, 1'b1, 0);
      repeat (3) @(negedge clk);

      prev_last = 0;
      for (int i = 0; i < 12; i++) begin
         s = (i >= 6);
         if (i == 6) begin
            repeat (4) @(negedge clk);
            prev_last = 0;
         end
         l = (i == 5 || i == 11) ? 1'b1 : 1'($urandom_range(0, 1));
         send(s, 16'($urandom), l, (prev_last != 0) ? (s ? 1 : 3) : 0);
         prev_last = int'(l);
      end

      repeat (4) @(negedge clk);
      sel = 1'b0;
      drive(16'hBEEF, 1'b1, 1'b1);
      check("rst_test_ready", obs(K_RDY), 1);
      t = int'(obs(K_RISES));
      @(negedge clk);
      drive(16'hBEEF, 1'b1, 1'b0);
      dn = 0;
      while (int'(obs(K_RISES)) - t < 5 && dn < 200) begin @(negedge clk); dn++; end
      check("rst_test_bits_reached", 32'(dn < 200), 1);
      res_a = 1'b1;
      @(negedge clk);
      res_a = 1'b0;
      #1;
      check("mid_rst_cs_n", obs(K_CS), 1);
      check("mid_rst_sck", obs(K_SCK), 0);
      check("mid_rst_mosi", obs(K_MOSI), 0);
      check("mid_rst_ready", obs(K_RDY), 1);
      check("mid_rst_busy", obs(K_BUSY), 0);
      check("mid_rst_done", obs(K_DONE), 0);
      dn = 0;
      repeat (100) begin
         @(negedge clk);
         if (obs(K_DONE) == 32'd1) dn++;
      end
      check("no_done_after_rst", dn, 0);
      check("cs_high_after_rst", obs(K_CS), 1);
      send(1'b0, 16'h5A3C, 1'b1, 0);
      check("mode3_mosi_moves_on_falling_only", b_bad, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
